// File: rtl/hada_pkg.sv
// rtl/hada_pkg.sv - hada package: abs/signum helpers and the signum-join classifier
//
// Purpose : shared types and functions for the hada streaming blocks.
//   abs*/signum*                  : per-width helpers (8/16/32/64).
//   signum_err_t                  : error code attached to every joined result.
//   signum_join_classify*         : rebuild x from (signum(x), abs(x)) and classify
//                                   the pair; returns {err, value}.
// Ports   : none (package).
package hada;

   typedef enum logic [1:0] {SJ_OK, SJ_BAD_SIGN, SJ_ZERO_MISMATCH, SJ_RANGE} signum_err_t;

   function automatic logic [7:0] abs8(input logic [7:0] x);
      return x[7] ? (~x + 8'd1) : x;
   endfunction

   function automatic logic [15:0] abs16(input logic [15:0] x);
      return x[15] ? (~x + 16'd1) : x;
   endfunction

   function automatic logic [31:0] abs32(input logic [31:0] x);
      return x[31] ? (~x + 32'd1) : x;
   endfunction

   function automatic logic [63:0] abs64(input logic [63:0] x);
      return x[63] ? (~x + 64'd1) : x;
   endfunction

   function automatic logic [7:0] signum8(input logic [7:0] x);
      return (x == '0) ? '0 : (x[7] ? '1 : 8'd1);
   endfunction

   function automatic logic [15:0] signum16(input logic [15:0] x);
      return (x == '0) ? '0 : (x[15] ? '1 : 16'd1);
   endfunction

   function automatic logic [31:0] signum32(input logic [31:0] x);
      return (x == '0) ? '0 : (x[31] ? '1 : 32'd1);
   endfunction

   function automatic logic [63:0] signum64(input logic [63:0] x);
      return (x == '0) ? '0 : (x[63] ? '1 : 64'd1);
   endfunction

   // Width-agnostic core: operands are zero-extended to 64 bits and only the
   // low w bits are meaningful. Returns {err[1:0], value[63:0]}.
   function automatic logic [65:0] signum_join_core(input logic [63:0] s,
                                                    input logic [63:0] m,
                                                    input int unsigned w);
      logic [63:0] mask;
      logic [63:0] sm;
      logic [63:0] mm;
      logic [63:0] neg;
      logic        is_min;
      mask   = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
      sm     = s & mask;
      mm     = m & mask;
      neg    = (~mm + 64'd1) & mask;
      // (-1, 2^(w-1)) is the most negative value, mirroring abs(min) == min.
      is_min = (sm == mask) && (mm == (64'd1 << (w - 1)));
      if (!((sm == '0) || (sm == 64'd1) || (sm == mask)))
         return {SJ_BAD_SIGN, 64'd0};
      else if ((sm == '0) != (mm == '0))
         return {SJ_ZERO_MISMATCH, 64'd0};
      else if (mm[w-1] && !is_min)
         return {SJ_RANGE, (sm == mask) ? neg : mm};
      else if (sm == mask)
         return {SJ_OK, neg};
      else
         return {SJ_OK, mm};
   endfunction

   function automatic logic [9:0] signum_join_classify8(input logic [7:0] s, input logic [7:0] m);
      logic [65:0] r;
      r = signum_join_core({56'd0, s}, {56'd0, m}, 8);
      return {r[65:64], r[7:0]};
   endfunction

   function automatic logic [17:0] signum_join_classify16(input logic [15:0] s, input logic [15:0] m);
      logic [65:0] r;
      r = signum_join_core({48'd0, s}, {48'd0, m}, 16);
      return {r[65:64], r[15:0]};
   endfunction

   function automatic logic [33:0] signum_join_classify32(input logic [31:0] s, input logic [31:0] m);
      logic [65:0] r;
      r = signum_join_core({32'd0, s}, {32'd0, m}, 32);
      return {r[65:64], r[31:0]};
   endfunction

   function automatic logic [65:0] signum_join_classify64(input logic [63:0] s, input logic [63:0] m);
      return signum_join_core(s, m, 64);
   endfunction

endpackage

// File: rtl/hada_skid_fifo.sv
// rtl/hada_skid_fifo.sv - generic 2-entry FIFO with occupancy output
//
// Purpose : two-deep register queue. in_ready and out_valid depend only on
//           registered occupancy, so there is no ready path from out to in.
// Ports   : clk, rst_n (async active-low)
//           in_valid/in_ready/in_data   : write side
//           out_valid/out_ready/out_data: read side, data from head register
//           count                       : occupancy 0..2
module hada_skid_fifo #(
   parameter int DW = 34
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data,
   output logic [1:0]    count
);

   logic [DW-1:0] mem0;
   logic [DW-1:0] mem1;
   logic          wr_ptr;
   logic          rd_ptr;
   logic          push;
   logic          pop;

   assign in_ready  = (count != 2'd2);
   assign out_valid = (count != 2'd0);
   assign out_data  = rd_ptr ? mem1 : mem0;
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem0   <= '0;
         mem1   <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) begin
            if (wr_ptr) mem1 <= in_data;
            else        mem0 <= in_data;
            wr_ptr <= ~wr_ptr;
         end
         if (pop)
            rd_ptr <= ~rd_ptr;
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/hada_signum_join.sv
// rtl/hada_signum_join.sv - streaming (signum, magnitude) to two's-complement join
//
// Purpose : classifies each input pair, queues {value, err} in a 2-entry FIFO
//           and counts erroneous pairs with a saturating counter.
// Ports   : clk, rst_n (async active-low)
//           in_valid/in_ready, in_sign[W], in_mag[W] : input pair stream
//           out_valid/out_ready, out_value[W], out_err[2] : result stream
//           err_count[CNT_W] : accepted pairs with non-zero error, saturating
module hada_signum_join
   import hada::*;
#(
   parameter int W     = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     in_sign,
   input  logic [W-1:0]     in_mag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     out_value,
   output logic [1:0]       out_err,
   output logic [CNT_W-1:0] err_count
);

   logic [W+1:0] cls;
   logic [W+1:0] head;
   logic [1:0]   count;
   signum_err_t  cls_err;

   generate
      if (W == 8) begin : g_w8
         assign cls = signum_join_classify8(in_sign, in_mag);
      end else if (W == 16) begin : g_w16
         assign cls = signum_join_classify16(in_sign, in_mag);
      end else if (W == 32) begin : g_w32
         assign cls = signum_join_classify32(in_sign, in_mag);
      end else begin : g_w64
         assign cls = signum_join_classify64(in_sign, in_mag);
      end
   endgenerate

   assign cls_err = signum_err_t'(cls[W+1:W]);

   hada_skid_fifo #(.DW(W + 2)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (cls),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (head),
      .count     (count)
   );

   assign out_value = head[W-1:0];
   assign out_err   = head[W+1:W];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         err_count <= '0;
      else if (in_valid && in_ready && (cls_err != SJ_OK) && (err_count != '1))
         err_count <= err_count + CNT_W'(1);
   end

endmodule

// File: tb/tb_hada_signum_join.sv
// tb/tb_hada_signum_join.sv - self-checking bench for hada_signum_join (W=8, CNT_W=4)
module tb_hada_signum_join;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_sign;
   logic [7:0] in_mag;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_value;
   logic [1:0] out_err;
   logic [3:0] err_count;

   hada_signum_join #(.W(8), .CNT_W(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_sign   (in_sign),
      .in_mag    (in_mag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_value (out_value),
      .out_err   (out_err),
      .err_count (err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int         tests = 0;
   int         fails = 0;
   int         ecnt  = 0;
   logic [9:0] q[$];
   logic       in_fired;
   logic       out_fired;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: value = signum * magnitude in plain integer arithmetic.
   function automatic logic [9:0] ref_join(input int s, input int m);
      int sg;
      int p;
      if (s == 0)        sg = 0;
      else if (s == 1)   sg = 1;
      else if (s == 255) sg = -1;
      else               return {2'd1, 8'd0};
      if ((sg == 0) != (m == 0)) return {2'd2, 8'd0};
      p = sg * m;
      if (m >= 128 && !(sg == -1 && m == 128)) return {2'd3, p[7:0]};
      return {2'd0, p[7:0]};
   endfunction

   // Advance one clock; update the queue model with the handshakes that
   // happened at the edge and check the DUT against it.
   task automatic tick();
      logic       inf;
      logic       outf;
      logic [9:0] e;
      inf  = in_valid && in_ready;
      outf = out_valid && out_ready;
      @(posedge clk);
      #1;
      if (outf && q.size() != 0) void'(q.pop_front());
      if (inf) begin
         e = ref_join(int'(in_sign), int'(in_mag));
         q.push_back(e);
         if (e[9:8] != 2'd0 && ecnt < 15) ecnt++;
      end
      in_fired  = inf;
      out_fired = outf;
      chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
      chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
      chk("err_count", 64'(err_count), 64'(ecnt));
      if (q.size() != 0) begin
         chk("head_value", 64'(out_value), 64'(q[0][7:0]));
         chk("head_err", 64'(out_err), 64'(q[0][9:8]));
      end
   endtask

   task automatic put(input logic [7:0] s, input logic [7:0] m);
      in_valid = 1'b1;
      in_sign  = s;
      in_mag   = m;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (in_fired) break;
      end
      chk("put_accept", 64'(in_fired), 64'd1);
   endtask

   task automatic drain();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (q.size() == 0) break;
         tick();
      end
      chk("drained", 64'(out_valid), 64'd0);
   endtask

   function automatic logic [7:0] rnd_sign();
      case ($urandom_range(0, 3))
         0:       return 8'd0;
         1:       return 8'd1;
         2:       return 8'hFF;
         default: return 8'($urandom);
      endcase
   endfunction

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_sign   = '0;
      in_mag    = '0;
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_value", 64'(out_value), 64'd0);
      chk("rst_out_err", 64'(out_err), 64'd0);
      chk("rst_err_count", 64'(err_count), 64'd0);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // legal pairs, back to back
      out_ready = 1'b1;
      put(8'd1, 8'd5);
      chk("lat_p5", 64'(out_value), 64'h05);
      put(8'hFF, 8'd5);
      chk("lat_m5", 64'(out_value), 64'hFB);
      put(8'd0, 8'd0);
      chk("lat_zero", 64'(out_value), 64'h00);
      put(8'hFF, 8'h80);
      chk("lat_min", 64'(out_value), 64'h80);
      chk("lat_min_err", 64'(out_err), 64'd0);

      // error pairs
      put(8'd2, 8'd3);
      chk("bad_sign_err", 64'(out_err), 64'd1);
      put(8'd0, 8'd7);
      chk("zm1_err", 64'(out_err), 64'd2);
      put(8'd1, 8'd0);
      chk("zm2_err", 64'(out_err), 64'd2);
      put(8'd1, 8'h80);
      chk("range1", 64'({out_err, out_value}), 64'h380);
      put(8'hFF, 8'h81);
      chk("range2", 64'({out_err, out_value}), 64'h37F);
      drain();
      chk("err_count5", 64'(err_count), 64'd5);

      // backpressure
      out_ready = 1'b0;
      put(rnd_sign(), 8'($urandom));
      put(rnd_sign(), 8'($urandom));
      chk("bp_in_ready_low", 64'(in_ready), 64'd0);
      in_sign = rnd_sign();
      in_mag  = 8'($urandom);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("bp_third_waits", 64'(in_fired), 64'd0);
      end
      out_ready = 1'b1;
      put(in_sign, in_mag);
      drain();

      // simultaneous push/pop at occupancy 1
      out_ready = 1'b0;
      put(rnd_sign(), 8'($urandom));
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1;
         in_sign  = rnd_sign();
         in_mag   = 8'($urandom);
         tick();
         chk("pp_in", 64'(in_fired), 64'd1);
         chk("pp_out", 64'(out_fired), 64'd1);
         chk("pp_occupancy", 64'(q.size()), 64'd1);
      end
      drain();

      // randomized traffic
      for (int i = 0; i < 60; i++) begin
         in_valid  = 1'($urandom_range(0, 1));
         out_ready = 1'($urandom_range(0, 1));
         in_sign   = rnd_sign();
         in_mag    = 8'($urandom);
         tick();
      end
      drain();

      // saturation of the error counter
      for (int i = 0; i < 20; i++)
         put(8'($urandom_range(2, 254)), 8'($urandom));
      drain();
      chk("err_sat", 64'(err_count), 64'd15);

      // reset with two entries queued
      out_ready = 1'b0;
      put(8'd1, 8'd9);
      put(8'hFF, 8'd9);
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
      chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
      chk("mid_rst_err_count", 64'(err_count), 64'd0);
      q.delete();
      ecnt = 0;
      @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      put(8'hFF, 8'd3);
      chk("post_rst_value", 64'({out_err, out_value}), 64'h0FD);
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/hada_signum_join.md
# hada_signum_join

Streaming inverse of the package's `abs`/`signum` helpers.
- Accepts (signum, magnitude) pairs and rebuilds the two's-complement value so that `signum(x) * abs(x) == x`.
- Classifies malformed pairs and buffers results in a 2-entry output queue with valid/ready on both sides.
- Sits after any datapath that carries values in sign/magnitude form, for example a magnitude-only ALU. It hands results back to two's-complement consumers.

## Interface
- `W`, 32, data width; legal values 8, 16, 32, 64 (matches the byte/shortint/int/longint helpers).
- `CNT_W`, 16, width of the saturating error counter.

- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  input pair present.
- `in_ready`  out  1  block can accept a pair this cycle.
- `in_sign`  in  W  signum, two's complement; legal values are 0, 1, all-ones (-1).
- `in_mag`  in  W  magnitude, unsigned.
- `out_valid`  out  1  result at head of queue.
- `out_ready`  in  1  consumer takes result this cycle.
- `out_value`  out  W  reconstructed value.
- `out_err`  out  2  error code of the result: 0 OK, 1 BAD_SIGN, 2 ZERO_MISMATCH, 3 RANGE.
- `err_count`  out  CNT_W  number of accepted pairs with `out_err != 0`; saturates at all-ones.

## Operation
- Transfer in: `in_valid && in_ready` at a rising edge.
- Transfer out: `out_valid && out_ready` at a rising edge.
- Classification is combinational on the input pair. The first matching rule wins, in priority order:
  1. BAD_SIGN: `in_sign` is not 0, 1 or all-ones. `out_value = 0`.
  2. ZERO_MISMATCH: `in_sign == 0` with `in_mag != 0`, or `in_sign != 0` with `in_mag == 0`. `out_value = 0`.
  3. RANGE: `in_mag[W-1] == 1`, except the pair (`in_sign` = -1, `in_mag` = 2^(W-1)). `out_value` is the product `in_sign*in_mag` truncated mod 2^W.
  4. OK: `out_value = in_mag` for +1, `0` for 0, and `(~in_mag)+1` truncated to W bits for -1.
- The (-1, 2^(W-1)) pair is OK and yields the most negative value. This is consistent with abs(min) wrapping to min.
- `{value, err}` is written into a 2-entry FIFO (sub-module `hada_skid_fifo`). The FIFO occupancy `count` ranges over 0..2.
- `in_ready = (count != 2)`. It is a function of registered state only; there is no combinational path from `out_ready` to `in_ready`.
- `out_valid = (count != 0)`. Output data is the FIFO head, driven straight from registers.
- `err_count` increments on every accepted input with a non-zero error and holds at all-ones.

## Timing
- Reset values, asynchronous on `rst_n` low:
  - `count = 0`, `in_ready = 1`, `out_valid = 0`.
  - `out_value = 0`, `out_err = 0`, `err_count = 0`.
  - The FIFO read and write pointers are 0.
- Latency: a pair accepted at edge N appears at the output with `out_valid` high after edge N; it is visible in cycle N+1 when the queue was empty.
- Throughput: 1 pair per cycle while `out_ready` is held high.
- Push and pop on the same edge:
  - `count` is unchanged.
  - At `count == 1`, the new entry becomes the head on the next cycle.
  - At `count == 2`, no push is possible because `in_ready` is low. The pop makes `in_ready` high in the next cycle.
- Output stability: while `out_valid && !out_ready`, `out_value` and `out_err` must stay stable.
- Pointers: both pointers are 1 bit wide and wrap 1→0.
- Reset mid-operation: queued entries are discarded, and `err_count` clears immediately.

## Structure
- Add the following to package `hada`:
  - `typedef enum logic [1:0] {SJ_OK, SJ_BAD_SIGN, SJ_ZERO_MISMATCH, SJ_RANGE} signum_err_t;`
  - A function `signum_join_classify`, parameterized by width through per-width variants (8/16/32/64) in the same style as `abs*`/`signum*`.
- Sub-module `hada_skid_fifo`: a generic 2-entry FIFO of width `W+2`, depth fixed at 2, with a `count` output. It is reused by other streaming blocks.
- The top level contains the classifier instance, the FIFO, and the saturating counter.

## Test plan
All scenarios use `W=8` and `CNT_W=4`.
- Legal pairs, with `out_ready` held at 1:
  - (1, 5) → 0x05, err 0.
  - (-1/0xFF, 5) → 0xFB, err 0.
  - (0, 0) → 0x00, err 0.
  - (0xFF, 0x80) → 0x80, err 0.
  - Each appears one cycle after acceptance, back to back.
- Errors:
  - (2, 3) → value 0, err 1.
  - (0, 7) → 0, err 2.
  - (1, 0) → 0, err 2.
  - (1, 0x80) → 0x80, err 3.
  - (0xFF, 0x81) → 0x7F, err 3.
  - After these five, `err_count = 5`.
- Backpressure:
  - Hold `out_ready=0` and push 3 pairs. `in_ready` drops after the second acceptance, and the third pair waits.
  - Then raise `out_ready`. Results emerge in order with no loss and no duplicates.
- Full push/pop: at `count=1`, assert `in_valid` and `out_ready` together for 10 cycles. The bench sees 10 in-order results, and `count` stays at 1.
- Saturation: feed 20 BAD_SIGN pairs. `err_count` stops at 15.
- Reset: assert `rst_n=0` with 2 entries queued. In the same cycle, `out_valid` goes to 0, `err_count` to 0 and `in_ready` to 1; after release the first new pair is output correctly.
